// File: rtl/fdtd_axi_pkg.sv
// Shared AXI constants and read-side FSM state type for the FDTD
// user-plugin register front ends.
//   RESP_*  : AXI response encodings
//   BURST_* : AXI burst-type encodings (BURST_RSVD is the illegal 2'b11)
//   rd_state_t : read front-end FSM states
package fdtd_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] BURST_RSVD  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    READ = 2'd1,
    SEND = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fdtd_reg_word_rd.sv
// AXI4 read-slave front end for the FDTD plugin register block.
// Accepts one AR transaction at a time and, for every beat, issues a
// one-cycle register read strobe (READ) and then presents the registered
// data on the R channel (SEND) until it is accepted.
// Ports:
//   ACLK, ARESET         clock, synchronous active-high reset
//   AR*_i / ARREADY_o    read-address channel (only ID, ADDR, LEN, BURST used)
//   R*_o / RREADY_i      read-data channel, all outputs registered/Moore
//   rd_req_o             register read strobe, one per beat
//   word_addr_o          register word address
//   rdata_i              register data, combinational from word_addr_o
module fdtd_reg_word_rd
  import fdtd_axi_pkg::*;
#(
  parameter int AXI4_ADDR_WIDTH = 32,
  parameter int AXI4_DATA_WIDTH = 32,
  parameter int AXI4_ID_WIDTH   = 16,
  parameter int AXI4_USER_WIDTH = 10,
  parameter int WORD_ADDR_WIDTH = 4
) (
  input  logic                       ACLK,
  input  logic                       ARESET,
  input  logic [AXI4_ID_WIDTH-1:0]   ARID_i,
  input  logic [AXI4_ADDR_WIDTH-1:0] ARADDR_i,
  input  logic [7:0]                 ARLEN_i,
  input  logic [2:0]                 ARSIZE_i,
  input  logic [1:0]                 ARBURST_i,
  input  logic                       ARLOCK_i,
  input  logic [3:0]                 ARCACHE_i,
  input  logic [2:0]                 ARPROT_i,
  input  logic [3:0]                 ARREGION_i,
  input  logic [3:0]                 ARQOS_i,
  input  logic [AXI4_USER_WIDTH-1:0] ARUSER_i,
  input  logic                       ARVALID_i,
  output logic                       ARREADY_o,
  output logic [AXI4_ID_WIDTH-1:0]   RID_o,
  output logic [AXI4_DATA_WIDTH-1:0] RDATA_o,
  output logic [1:0]                 RRESP_o,
  output logic                       RLAST_o,
  output logic [AXI4_USER_WIDTH-1:0] RUSER_o,
  output logic                       RVALID_o,
  input  logic                       RREADY_i,
  output logic                       rd_req_o,
  output logic [WORD_ADDR_WIDTH-1:0] word_addr_o,
  input  logic [AXI4_DATA_WIDTH-1:0] rdata_i
);

  rd_state_t                  state;
  logic [AXI4_ID_WIDTH-1:0]   r_id;
  logic [WORD_ADDR_WIDTH-1:0] r_addr;
  logic [7:0]                 r_len;
  logic [1:0]                 r_burst;
  logic [7:0]                 beat_cnt;
  logic [AXI4_DATA_WIDTH-1:0] r_rdata;

  logic rsvd;
  logic last;

  assign rsvd = (r_burst == BURST_RSVD);
  // beat_cnt never passes r_len, so an ARLEN of 255 terminates at 255
  // without the 8-bit counter wrapping.
  assign last = (beat_cnt == r_len);

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state    <= IDLE;
      r_id     <= '0;
      r_addr   <= '0;
      r_len    <= '0;
      r_burst  <= BURST_FIXED;
      beat_cnt <= '0;
      r_rdata  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (ARVALID_i) begin
            r_id     <= ARID_i;
            r_addr   <= ARADDR_i[WORD_ADDR_WIDTH+1:2];
            r_len    <= ARLEN_i;
            r_burst  <= ARBURST_i;
            beat_cnt <= '0;
            state    <= READ;
          end
        end
        READ: begin
          // Reserved bursts return zero data; the strobe is gated off below.
          r_rdata <= rsvd ? '0 : rdata_i;
          state   <= SEND;
        end
        SEND: begin
          if (RREADY_i) begin
            if (last) begin
              state <= IDLE;
            end else begin
              // WRAP is deliberately handled as INCR; the address space
              // wraps naturally at 2^WORD_ADDR_WIDTH.
              if (r_burst != BURST_FIXED) r_addr <= r_addr + 1'b1;
              beat_cnt <= beat_cnt + 8'd1;
              state    <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign ARREADY_o   = (state == IDLE);
  assign rd_req_o    = (state == READ) && !rsvd;
  assign word_addr_o = r_addr;
  assign RVALID_o    = (state == SEND);
  assign RLAST_o     = (state == SEND) && last;
  assign RRESP_o     = ((state == SEND) && rsvd) ? RESP_SLVERR : RESP_OKAY;
  assign RID_o       = r_id;
  assign RDATA_o     = r_rdata;
  assign RUSER_o     = '0;

  // Sideband AR fields carry no meaning for a register block.
  logic unused_ar;
  assign unused_ar = ^{ARADDR_i, ARSIZE_i, ARLOCK_i, ARCACHE_i, ARPROT_i,
                       ARREGION_i, ARQOS_i, ARUSER_i};

endmodule

// File: tb/tb_fdtd_reg_word_rd.sv
module tb_fdtd_reg_word_rd;
  import fdtd_axi_pkg::*;

  localparam int AW  = 32;
  localparam int DW  = 32;
  localparam int IW  = 16;
  localparam int UW  = 10;
  localparam int WAW = 4;

  logic          ACLK = 1'b0;
  logic          ARESET;
  logic [IW-1:0] ARID_i;
  logic [AW-1:0] ARADDR_i;
  logic [7:0]    ARLEN_i;
  logic [2:0]    ARSIZE_i;
  logic [1:0]    ARBURST_i;
  logic          ARLOCK_i;
  logic [3:0]    ARCACHE_i;
  logic [2:0]    ARPROT_i;
  logic [3:0]    ARREGION_i;
  logic [3:0]    ARQOS_i;
  logic [UW-1:0] ARUSER_i;
  logic          ARVALID_i;
  logic          ARREADY_o;
  logic [IW-1:0] RID_o;
  logic [DW-1:0] RDATA_o;
  logic [1:0]    RRESP_o;
  logic          RLAST_o;
  logic [UW-1:0] RUSER_o;
  logic          RVALID_o;
  logic          RREADY_i;
  logic          rd_req_o;
  logic [WAW-1:0] word_addr_o;
  logic [DW-1:0] rdata_i;

  logic [DW-1:0] regs [16];
  assign rdata_i = regs[word_addr_o];

  always #5 ACLK = ~ACLK;

  fdtd_reg_word_rd #(
    .AXI4_ADDR_WIDTH(AW), .AXI4_DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW),
    .AXI4_USER_WIDTH(UW), .WORD_ADDR_WIDTH(WAW)
  ) dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .ARID_i(ARID_i), .ARADDR_i(ARADDR_i), .ARLEN_i(ARLEN_i), .ARSIZE_i(ARSIZE_i),
    .ARBURST_i(ARBURST_i), .ARLOCK_i(ARLOCK_i), .ARCACHE_i(ARCACHE_i),
    .ARPROT_i(ARPROT_i), .ARREGION_i(ARREGION_i), .ARQOS_i(ARQOS_i),
    .ARUSER_i(ARUSER_i), .ARVALID_i(ARVALID_i), .ARREADY_o(ARREADY_o),
    .RID_o(RID_o), .RDATA_o(RDATA_o), .RRESP_o(RRESP_o), .RLAST_o(RLAST_o),
    .RUSER_o(RUSER_o), .RVALID_o(RVALID_o), .RREADY_i(RREADY_i),
    .rd_req_o(rd_req_o), .word_addr_o(word_addr_o), .rdata_i(rdata_i)
  );

  typedef struct {
    logic [DW-1:0] data;
    logic [IW-1:0] id;
    logic [1:0]    resp;
    logic          last;
  } beat_t;

  beat_t          beat_q [$];
  logic [WAW-1:0] req_q  [$];
  logic [WAW-1:0] req_log[$];
  logic [DW-1:0]  data_log[$];

  int tests = 0;
  int fails = 0;
  int beats_total = 0;
  int reqs_total = 0;
  int beat_base = 0;
  int req_base = 0;
  int rmode = 0;
  bit run = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: expand one AR request into its expected register reads and
  // R beats straight from the burst rules.
  task automatic push_model(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                            input int len, input logic [1:0] burst);
    logic [WAW-1:0] w0, wa;
    beat_t b;
    w0 = addr[WAW+1:2];
    for (int i = 0; i <= len; i++) begin
      wa = (burst == BURST_FIXED) ? w0 : WAW'((int'(w0) + i) % 16);
      if (burst != BURST_RSVD) req_q.push_back(wa);
      b.data = (burst == BURST_RSVD) ? '0 : regs[wa];
      b.id   = id;
      b.resp = (burst == BURST_RSVD) ? RESP_SLVERR : RESP_OKAY;
      b.last = (i == len);
      beat_q.push_back(b);
    end
  endtask

  task automatic issue_ar(input logic [IW-1:0] id, input logic [AW-1:0] addr,
                          input int len, input logic [1:0] burst);
    bit ok;
    push_model(id, addr, len, burst);
    beat_base = beats_total;
    req_base  = reqs_total;
    ARID_i = id; ARADDR_i = addr; ARLEN_i = 8'(len); ARBURST_i = burst;
    ARSIZE_i = 3'($urandom); ARLOCK_i = 1'($urandom); ARCACHE_i = 4'($urandom);
    ARPROT_i = 3'($urandom); ARREGION_i = 4'($urandom); ARQOS_i = 4'($urandom);
    ARUSER_i = UW'($urandom);
    ARVALID_i = 1'b1;
    ok = 0;
    for (int c = 0; c < 50; c++) begin
      @(negedge ACLK);
      if (ARREADY_o) begin ok = 1; break; end
    end
    check("ar_accept", 64'(ok), 64'(1));
    @(posedge ACLK); #1;
    ARVALID_i = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int c = 0;
    while (beat_q.size() != 0 && c < budget) begin
      @(posedge ACLK); #1;
      c++;
    end
    check("drain_empty", 64'(beat_q.size()), 64'(0));
    check("req_drain_empty", 64'(req_q.size()), 64'(0));
    beat_q.delete();
    req_q.delete();
  endtask

  // Compare process: every cycle, DUT outputs against the model queues.
  initial begin
    beat_t b;
    logic [WAW-1:0] ea;
    forever begin
      @(negedge ACLK);
      if (run && !ARESET) begin
        if (!ARVALID_i) check("arready", 64'(ARREADY_o), 64'(beat_q.size() == 0));
        check("ruser", 64'(RUSER_o), 64'(0));
        if (rd_req_o) begin
          check("req_not_in_send", 64'(RVALID_o), 64'(0));
          check("req_expected", 64'(req_q.size() != 0), 64'(1));
          if (req_q.size() != 0) begin
            ea = req_q.pop_front();
            check("word_addr", 64'(word_addr_o), 64'(ea));
          end
          req_log.push_back(word_addr_o);
          reqs_total++;
        end
        if (RVALID_o) begin
          check("beat_expected", 64'(beat_q.size() != 0), 64'(1));
          if (beat_q.size() != 0) begin
            b = beat_q[0];
            check("rdata", 64'(RDATA_o), 64'(b.data));
            check("rid",   64'(RID_o),   64'(b.id));
            check("rresp", 64'(RRESP_o), 64'(b.resp));
            check("rlast", 64'(RLAST_o), 64'(b.last));
            if (RREADY_i) begin
              data_log.push_back(RDATA_o);
              void'(beat_q.pop_front());
              beats_total++;
            end
          end
        end
      end
    end
  end

  // RREADY driver: 0 = always ready, 1 = random, 2 = three stall cycles on beat 1.
  initial begin
    int stall = 0;
    RREADY_i = 1'b0;
    forever begin
      @(posedge ACLK); #1;
      case (rmode)
        0: begin RREADY_i = 1'b1; stall = 0; end
        1: begin RREADY_i = ($urandom_range(0, 3) != 0); stall = 0; end
        default: begin
          if (RVALID_o && (beats_total - beat_base) == 1 && stall < 3) begin
            RREADY_i = 1'b0;
            stall++;
          end else begin
            RREADY_i = 1'b1;
          end
        end
      endcase
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int base;
    bit hit;
    ARESET = 1'b1; ARVALID_i = 1'b0; ARID_i = '0; ARADDR_i = '0; ARLEN_i = '0;
    ARBURST_i = '0; ARSIZE_i = '0; ARLOCK_i = '0; ARCACHE_i = '0; ARPROT_i = '0;
    ARREGION_i = '0; ARQOS_i = '0; ARUSER_i = '0;
    for (int i = 0; i < 16; i++) regs[i] = 32'hA5A5_0000 | (32'(i) * 32'h0101);
    repeat (3) @(posedge ACLK);
    #1;
    check("rst_arready", 64'(ARREADY_o), 64'(1));
    check("rst_rvalid",  64'(RVALID_o),  64'(0));
    check("rst_rlast",   64'(RLAST_o),   64'(0));
    check("rst_rd_req",  64'(rd_req_o),  64'(0));
    check("rst_rid",     64'(RID_o),     64'(0));
    check("rst_rdata",   64'(RDATA_o),   64'(0));
    check("rst_waddr",   64'(word_addr_o), 64'(0));
    check("rst_rresp",   64'(RRESP_o),   64'(RESP_OKAY));
    ARESET = 1'b0;
    run = 1;
    @(posedge ACLK); #1;

    // Single beat, latency pinned with literals.
    rmode = 0;
    issue_ar(16'h005A, 32'h08, 0, BURST_INCR);
    check("t1_req_n1",   64'(rd_req_o), 64'(1));
    check("t1_waddr_n1", 64'(word_addr_o), 64'(2));
    @(posedge ACLK); #1;
    check("t1_rvalid_n2", 64'(RVALID_o), 64'(1));
    check("t1_rlast",     64'(RLAST_o), 64'(1));
    check("t1_rid",       64'(RID_o), 64'(16'h5A));
    check("t1_rdata",     64'(RDATA_o), 64'(32'hA5A5_0202));
    wait_done(50);
    check("t1_nreq", 64'(reqs_total - req_base), 64'(1));
    @(posedge ACLK); #1;

    // INCR with a stall on beat 1.
    rmode = 2;
    issue_ar(16'h0001, 32'h04, 3, BURST_INCR);
    wait_done(100);
    check("t2_nreq", 64'(reqs_total - req_base), 64'(4));
    for (int k = 0; k < 4; k++) check("t2_addr", 64'(req_log[req_base + k]), 64'(1 + k));
    check("t2_beat1", 64'(data_log[beat_base + 1]), 64'(32'hA5A5_0202));

    // Address wrap at 2^WAW.
    rmode = 1;
    issue_ar(16'h0002, 32'h38, 3, BURST_INCR);
    wait_done(300);
    begin
      int exp_a [4] = '{14, 15, 0, 1};
      for (int k = 0; k < 4; k++) check("t3_addr", 64'(req_log[req_base + k]), 64'(exp_a[k]));
    end

    // FIXED.
    rmode = 0;
    issue_ar(16'h0003, 32'h0C, 2, BURST_FIXED);
    wait_done(100);
    check("t4_nreq", 64'(reqs_total - req_base), 64'(3));
    for (int k = 0; k < 3; k++) check("t4_addr", 64'(req_log[req_base + k]), 64'(3));
    check("t4_nbeat", 64'(beats_total - beat_base), 64'(3));

    // Reserved burst type.
    issue_ar(16'h0004, 32'h10, 1, BURST_RSVD);
    wait_done(100);
    check("t5_nreq", 64'(reqs_total - req_base), 64'(0));
    check("t5_nbeat", 64'(beats_total - beat_base), 64'(2));
    check("t5_data", 64'(data_log[beat_base + 1]), 64'(0));

    // Reset during beat 2 of an 8-beat burst.
    issue_ar(16'h0007, 32'h00, 7, BURST_INCR);
    hit = 0;
    for (int c = 0; c < 100; c++) begin
      @(posedge ACLK); #1;
      if (RVALID_o && (beats_total - beat_base) == 2) begin hit = 1; break; end
    end
    check("t6_reach_beat2", 64'(hit), 64'(1));
    ARESET = 1'b1;
    beat_q.delete();
    req_q.delete();
    @(posedge ACLK); #1;
    ARESET = 1'b0;
    check("t6_rvalid", 64'(RVALID_o), 64'(0));
    check("t6_arready", 64'(ARREADY_o), 64'(1));
    base = req_base;
    repeat (4) @(posedge ACLK);
    #1;
    check("t6_nreq", 64'(reqs_total - base), 64'(3));
    issue_ar(16'h0008, 32'h14, 0, BURST_INCR);
    wait_done(50);
    check("t6_after_nbeat", 64'(beats_total - beat_base), 64'(1));
    check("t6_after_data", 64'(data_log[beat_base]), 64'(32'hA5A5_0505));

    // Randomized traffic against the model.
    for (int i = 0; i < 16; i++) regs[i] = $urandom;
    rmode = 1;
    for (int n = 0; n < 40; n++) begin
      int len;
      len = $urandom_range(0, 15);
      issue_ar(IW'($urandom), $urandom, len, 2'($urandom_range(0, 3)));
      wait_done(64 * (len + 1) + 50);
      repeat ($urandom_range(0, 2)) @(posedge ACLK);
      #1;
    end

    // Longest burst.
    rmode = 0;
    issue_ar(16'hBEEF, 32'h24, 255, BURST_INCR);
    wait_done(2000);
    check("t7_nbeat", 64'(beats_total - beat_base), 64'(256));
    check("t7_nreq", 64'(reqs_total - req_base), 64'(256));

    repeat (3) @(posedge ACLK);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fdtd_reg_word_rd.md
# fdtd_reg_word_rd

AXI4 read-slave front end for the FDTD user-plugin register block. It accepts AXI read-address transactions and drives a simple word-addressed register read port. It returns one read-data beat per AXI beat, supporting FIXED and INCR bursts of up to 256 beats. It is the read-direction counterpart of the plugin's AXI write front end and shares its address decoding: word address = ADDR[WORD_ADDR_WIDTH+1:2].

## Interface
- AXI4_ADDR_WIDTH, 32, address width.
- AXI4_DATA_WIDTH, 32, data width; also the register width.
- AXI4_ID_WIDTH, 16, transaction ID width.
- AXI4_USER_WIDTH, 10, user-signal width.
- WORD_ADDR_WIDTH, 4, register word-address width.

- ACLK  in  1  single clock; all logic is on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- ARID_i, ARADDR_i, ARLEN_i[7:0], ARBURST_i[1:0]  in  per AXI4  read address, ID, length and burst type.
- ARSIZE_i, ARLOCK_i, ARCACHE_i, ARPROT_i, ARREGION_i, ARQOS_i, ARUSER_i  in  per AXI4  ignored.
- ARVALID_i  in  1;  ARREADY_o  out  1.
- RID_o  out  AXI4_ID_WIDTH  echoes the captured ARID.
- RDATA_o  out  AXI4_DATA_WIDTH  registered read data.
- RRESP_o  out  2  OKAY (00) or SLVERR (10).
- RLAST_o  out  1  final beat of the burst.
- RUSER_o  out  AXI4_USER_WIDTH  constant 0.
- RVALID_o  out  1;  RREADY_i  in  1.
- rd_req_o  out  1  one-cycle register read strobe.
- word_addr_o  out  WORD_ADDR_WIDTH  register word address; valid while rd_req_o is high.
- rdata_i  in  AXI4_DATA_WIDTH  register data; combinational response to word_addr_o, sampled in the cycle rd_req_o is high.

## Operation
- The FSM has three states: IDLE, READ and SEND. Reset enters IDLE.
- IDLE:
  - ARREADY_o=1.
  - On ARVALID_i, capture ARID, the word address, ARLEN into r_len and ARBURST; clear beat_cnt; go to READ.
- READ:
  - rd_req_o=1 and word_addr_o=r_addr.
  - At the clock edge, latch r_rdata <= rdata_i (or 0 on error) and go to SEND.
- SEND:
  - RVALID_o=1 and RDATA_o=r_rdata.
  - RLAST_o = (beat_cnt == r_len).
  - RRESP_o = SLVERR if the captured burst is the reserved type 2'b11, else OKAY.
  - On RREADY_i with RLAST_o high, go to IDLE.
  - On RREADY_i otherwise, advance the address, increment beat_cnt and go to READ.
  - With RREADY_i low, stay in SEND; RDATA, RLAST and RRESP are held stable.
- Address advance:
  - FIXED (00): r_addr unchanged.
  - INCR (01) and WRAP (10): r_addr+1, modulo 2^WORD_ADDR_WIDTH. WRAP is treated as INCR.
  - Reserved (11): the address advances as for INCR, but rd_req_o is suppressed on every beat and RDATA_o=0.
- beat_cnt is 8 bits. A burst has r_len+1 beats; ARLEN=255 gives 256 beats with no counter overflow.
- rd_req_o fires exactly once per beat, and never while in SEND. Register reads therefore have no side effects from back-pressure.
- Only one transaction is outstanding at a time; ARREADY_o=0 outside IDLE.

## Timing
- All outputs are Moore outputs decoded from the state and registers. There is no combinational path from RREADY_i or ARVALID_i to any output.
- Reset values:
  - State = IDLE, so ARREADY_o=1 in the first cycle after reset.
  - RVALID_o, RLAST_o, rd_req_o = 0.
  - RID_o, RDATA_o, word_addr_o = 0.
  - RRESP_o = OKAY.
- Latency:
  - AR handshake at edge N.
  - rd_req_o high in cycle N+1.
  - RVALID_o high from cycle N+2.
- Throughput is one beat per 2 cycles with RREADY_i held high.
- After the final R handshake at edge M, ARREADY_o=1 in cycle M+1.
- ARESET asserted mid-burst: the next edge returns to IDLE, RVALID_o drops and the burst is abandoned. No further rd_req_o is issued.

## Structure
- Shared package fdtd_axi_pkg holds:
  - Response constants RESP_OKAY, RESP_EXOKAY, RESP_SLVERR, RESP_DECERR.
  - Burst constants BURST_FIXED, BURST_INCR, BURST_WRAP.
  - The rd_state_t enum {IDLE, READ, SEND}.
- This block is a single module with no natural sub-module. The address and beat logic is a few registers and does not merit separation.

## Test plan
- Single beat, INCR, ARADDR=0x08, ARID=0x5A, ARLEN=0, RREADY=1:
  - rd_req_o with word_addr_o=2 one cycle after the AR handshake.
  - One R beat: RDATA = reg[2], RID=0x5A, RLAST=1, OKAY.
- INCR burst, ARADDR=0x04, ARLEN=3, RREADY low for 3 cycles on beat 1:
  - Word addresses 1,2,3,4 issued.
  - Beat-1 data stable while stalled.
  - RLAST only on beat 3.
  - Exactly 4 rd_req_o pulses.
- Wrap-around, ARADDR=0x38, ARLEN=3, WORD_ADDR_WIDTH=4:
  - Word addresses 14,15,0,1.
- FIXED burst, ARADDR=0x0C, ARLEN=2:
  - Word address 3 issued three times; three beats, with RLAST on the third.
- Reserved burst 2'b11, ARLEN=1:
  - Two beats with RRESP=SLVERR and RDATA=0.
  - Zero rd_req_o pulses.
- ARESET pulsed during beat 2 of an 8-beat burst:
  - RVALID_o=0 and ARREADY_o=1 in the cycle after the reset edge.
  - A new single-beat read then completes normally.
